instr_prefetch_unit: RTL and testbench
======================================

# instr_prefetch_unit

Fetch-side front end of the pipeline: issues word requests to instruction memory, buffers returned instructions with their PC in a small FIFO, and presents them to the decode stage over a valid/ready handshake. It sits directly upstream of decode and accepts PC redirects from the memory stage (taken branch / jump `condpc`), flushing everything fetched down the wrong path.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_1000: first fetch address after reset.
- `clk`  in  1  pipeline clock.
- `rst_n`  in  1  asynchronous, active-low reset. One clock.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  word address of the request; bits [1:0] always 0.
- `imem_gnt`  in  1  memory accepts the request this cycle (`imem_req & imem_gnt` = issued).
- `imem_rvalid`  in  1  response data valid, never earlier than the cycle after grant.
- `imem_rdata`  in  32  instruction word.
- `redirect_valid`  in  1  change the fetch PC this cycle.
- `redirect_pc`  in  32  new fetch PC.
- `fd_valid`  out  1  FIFO head valid toward decode.
- `fd_ready`  in  1  decode accepts the head.
- `fd_instr`  out  32  head instruction.
- `fd_pc`  out  32  head PC.
- `fd_npc`  out  32  `fd_pc + 4`, wraps mod 2^32.
- `fetch_fault`  out  1  misaligned redirect (present only with the macro below).

## Operation
- At most one outstanding request. FSM states:
  - `S_REQ`: drive `imem_req`. Grant moves to `S_WAIT`.
  - `S_WAIT`: await `imem_rvalid`. On response, push {rdata, pc}, fetch PC += 4, go to `S_REQ`.
  - `S_DRAIN`: a squashed request is in flight. Its response is discarded, then go to `S_REQ`.
  - `S_FAULT`: macro only.
- Request gating: `imem_req` only when `count + outstanding < DEPTH`, using registered count.
- Redirect takes priority over everything in the same cycle:
  - FIFO cleared, so `fd_valid` = 0 next cycle.
  - Fetch PC loaded with `redirect_pc`.
  - From `S_WAIT`, or `S_REQ` granted that cycle: go to `S_DRAIN`. Otherwise go to `S_REQ`.
  - `imem_req` is forced to 0 during the redirect cycle.
- Redirect with `imem_rvalid` in the same cycle: data dropped and FSM goes to `S_REQ`.
- Redirect with `fd_valid & fd_ready` in the same cycle: the pop is void for bookkeeping; the flush wins.
- Redirect while in `S_DRAIN`: the new PC is loaded and the FSM stays in `S_DRAIN`.
- Push and pop in the same cycle: count unchanged. Allowed when full, since the pop frees the slot.
- Pointer wrap modulo `DEPTH`. `count` is $clog2(DEPTH)+1 bits.
- `fd_*` outputs hold stable while `fd_valid & !fd_ready`.

## Timing
- Reset values:
  - `imem_req` = 0, `imem_addr` = 0.
  - `fd_valid` = 0; `fd_instr`, `fd_pc`, `fd_npc` = 0.
  - `fetch_fault` = 0.
  - FSM `S_REQ`, fetch PC = `RESET_PC`.
- First cycle after reset release: `imem_req` = 1, `imem_addr` = `RESET_PC`.
- Latency, single-cycle memory (grant in cycle N, rvalid in N+1): push at the end of N+1, `fd_valid` in N+2. There is no bypass path.
- Sustained throughput: one instruction per 2 cycles, a consequence of the single-outstanding rule.
- Reset asserted mid-operation: immediate asynchronous clear. Any in-flight response arriving after release is ignored because the FSM is in `S_REQ`.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - `redirect_pc[1:0] != 0` enters `S_FAULT`: no requests issued, FIFO flushed, `fetch_fault` = 1 (sticky).
  - The next aligned redirect clears the fault and resumes fetch.
- `FETCH_ALIGN_CHECK_EN` undefined:
  - `redirect_pc[1:0]` is forced to 0.
  - The `fetch_fault` port and `S_FAULT` are absent.

## Structure
- `riscv_pkg` additions:
  - `fetch_entry_t` struct {`instr` [31:0], `pc` [31:0]}.
  - `fetch_state_e` enum {`S_REQ`, `S_WAIT`, `S_DRAIN`, `S_FAULT`}.
- Sub-module `fetch_fifo`: parameterized by `DEPTH`, with push/pop/flush/count and registered head output. The FSM, PC register and request gating stay in `instr_prefetch_unit`.

## Test plan
- Reset, `imem_gnt` = 1, 1-cycle memory returning `addr ^ 32'hA5A5_0000`, `fd_ready` = 1 → `fd_pc` sequence 0x1000, 0x1004, 0x1008; `fd_npc` = `fd_pc + 4`; first `fd_valid` 2 cycles after the first grant.
- `fd_ready` = 0 for 20 cycles → exactly `DEPTH` (4) entries buffered, then `imem_req` stays 0. Release → entries drain in order, no loss or duplicate.
- Redirect to 0x2000 in the cycle after a grant to 0x1008 → response for 0x1008 is dropped; next `fd_pc` = 0x2000.
- Redirect to 0x3000 coincident with `imem_rvalid` and `fd_ready` → FIFO empty next cycle; next request address = 0x3000.
- Assert `rst_n` = 0 while in `S_WAIT` → all outputs clear immediately; after release the first request is to 0x1000 and a stale rvalid is ignored.
- Macro on: redirect to 0x1002 → `fetch_fault` = 1 and no `imem_req`; then redirect to 0x1010 → fault clears and fetch resumes at 0x1010. Macro off: 0x1002 fetches from 0x1000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-side types: FIFO entry and prefetch FSM states.
// S_FAULT exists only when FETCH_ALIGN_CHECK_EN is defined.
package riscv_pkg;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_DRAIN
`ifdef FETCH_ALIGN_CHECK_EN
      , S_FAULT
`endif
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction FIFO with registered head; the head tracks the entry that
// will be oldest after this cycle's push/pop/flush, so it has no bypass.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [31:0]            instr_i,
   input  logic [31:0]            pc_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   valid_o,
   output logic [31:0]            instr_o,
   output logic [31:0]            pc_o,
   output logic [31:0]            npc_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  din;
   fetch_entry_t  head_d, head_q;
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d, rem;
   logic          pop_ok, valid_q, valid_d;
   logic [31:0]   npc_q;

   assign din    = '{instr: instr_i, pc: pc_i};
   assign pop_ok = pop_i & (cnt_q != '0);
   assign rem    = cnt_q - CW'(pop_ok);

   always_comb begin
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_ok);
      rd_d  = rd_q + AW'(pop_ok);
      wr_d  = wr_q + AW'(push_i);
      if (flush_i) begin
         cnt_d = '0;
         rd_d  = '0;
         wr_d  = '0;
      end
      valid_d = (cnt_d != '0);
      // With nothing left behind the pop, the incoming word becomes head
      head_d  = (rem == '0) ? din : mem_q[rd_d];
   end

   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_q] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         head_q  <= '0;
         npc_q   <= '0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         if (valid_d) begin
            head_q <= head_d;
            npc_q  <= head_d.pc + 32'd4;
         end
      end
   end

   assign count_o = cnt_q;
   assign valid_o = valid_q;
   assign instr_o = head_q.instr;
   assign pc_o    = head_q.pc;
   assign npc_o   = npc_q;

endmodule

// File: rtl/instr_prefetch_unit.sv
// Fetch front end: single-outstanding imem requests into fetch_fifo.
// Optional FETCH_ALIGN_CHECK_EN traps misaligned redirects as a sticky fault.
module instr_prefetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic        fetch_fault,
`endif
   output logic        fd_valid,
   input  logic        fd_ready,
   output logic [31:0] fd_instr,
   output logic [31:0] fd_pc,
   output logic [31:0] fd_npc
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned IW = CW + 1;

   fetch_state_e  state_q;
   logic [31:0]   pc_q;
   logic [CW-1:0] cnt;
   logic [IW-1:0] inflight;
   logic [31:0]   redir_pc;
   logic          outstanding, room, gnt, push, pop;

   assign outstanding = (state_q == S_WAIT) || (state_q == S_DRAIN);
   assign inflight    = IW'(cnt) + IW'(outstanding);
   assign room        = inflight < IW'(DEPTH);
   // Held low in reset so the request only appears once rst_n releases
   assign imem_req    = rst_n & (state_q == S_REQ) & room & ~redirect_valid;
   assign imem_addr   = rst_n ? pc_q : '0;
   assign gnt         = imem_req & imem_gnt;
   assign push        = (state_q == S_WAIT) & imem_rvalid & ~redirect_valid;
   assign pop         = fd_valid & fd_ready & ~redirect_valid;
   assign redir_pc    = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
   logic misalign, fault_q;
   assign misalign    = (redirect_pc[1:0] != 2'b00);
   assign fetch_fault = fault_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
`ifdef FETCH_ALIGN_CHECK_EN
         fault_q <= 1'b0;
`endif
      end else if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
         fault_q <= misalign;
         if (!misalign) pc_q <= redir_pc;
`else
         pc_q <= redir_pc;
`endif
         unique case (state_q)
            S_WAIT, S_DRAIN: state_q <= imem_rvalid ? S_REQ : S_DRAIN;
            S_REQ:           state_q <= gnt ? S_DRAIN : S_REQ;
            default:         state_q <= S_REQ;
         endcase
`ifdef FETCH_ALIGN_CHECK_EN
         if (misalign) state_q <= S_FAULT;
`endif
      end else begin
         unique case (state_q)
            S_REQ: if (gnt) state_q <= S_WAIT;
            S_WAIT: begin
               if (imem_rvalid) begin
                  pc_q    <= pc_q + 32'd4;
                  state_q <= S_REQ;
               end
            end
            S_DRAIN: if (imem_rvalid) state_q <= S_REQ;
            default: state_q <= state_q;
         endcase
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .instr_i (imem_rdata),
      .pc_i    (pc_q),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .count_o (cnt),
      .valid_o (fd_valid),
      .instr_o (fd_instr),
      .pc_o    (fd_pc),
      .npc_o   (fd_npc)
   );

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit: expected PCs queued by stimulus,
// checked by an independent monitor on each decode handshake.
module tb_instr_prefetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fd_valid, fd_ready;
   logic [31:0] fd_instr, fd_pc, fd_npc;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        fetch_fault;
`endif

   instr_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_1000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
`ifdef FETCH_ALIGN_CHECK_EN
      .fetch_fault    (fetch_fault),
`endif
      .fd_valid       (fd_valid),
      .fd_ready       (fd_ready),
      .fd_instr       (fd_instr),
      .fd_pc          (fd_pc),
      .fd_npc         (fd_npc)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] XMASK = 32'hA5A5_0000;

   int          total = 0;
   int          bad = 0;
   int          cyc_n = 0;
   int          ngrant = 0;
   int          first_gnt = -1;
   int          first_vld = -1;
   logic [31:0] sb_q [$];
   logic        rdy = 1'b1;
   logic        gnt = 1'b1;
   logic        slow = 1'b0;
   logic        p1_v = 1'b0, p2_v = 1'b0;
   logic [31:0] p1_d = '0, p2_d = '0;
   logic        last_gnt = 1'b0, last_req = 1'b0;
   logic [31:0] last_addr = '0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // One cycle: drive inputs at negedge, then record request/grant
   task automatic tick(input logic rv = 1'b0,
                       input logic [31:0] rp = '0,
                       input logic rel = 1'b0);
      @(negedge clk);
      cyc_n++;
      if (rel) rst_n = 1'b1;
      redirect_valid = rv;
      redirect_pc    = rp;
      fd_ready       = rdy;
      imem_gnt       = gnt;
      imem_rvalid    = slow ? p2_v : p1_v;
      imem_rdata     = slow ? p2_d : p1_d;
      #1;
      last_req  = imem_req;
      last_gnt  = imem_req & imem_gnt;
      last_addr = imem_addr;
      if (last_gnt) begin
         ngrant++;
         if (first_gnt < 0) first_gnt = cyc_n;
      end
      p2_v = p1_v;
      p2_d = p1_d;
      p1_v = last_gnt;
      p1_d = imem_addr ^ XMASK;
   endtask

   task automatic wait_grant(input string nm, input logic [31:0] a);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!(last_gnt && last_addr == a) && n < 50);
      total++;
      if (!(last_gnt && last_addr == a)) begin
         bad++;
         $display("FAIL %s: no grant to %h within 50 cycles", nm, a);
      end
   endtask

   // Monitor: every accepted head must match the oldest expected PC
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && fd_valid && fd_ready && !redirect_valid) begin
            if (first_vld < 0) first_vld = cyc_n;
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_out: got pc %h want none", fd_pc);
            end else begin
               e = sb_q.pop_front();
               chk("fd_pc", fd_pc, e);
               chk("fd_instr", fd_instr, e ^ XMASK);
               chk("fd_npc", fd_npc, e + 32'd4);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int g0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = '0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      fd_ready = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_valid", fd_valid, 0);
      chk("rst_instr", fd_instr, 0);
      chk("rst_pc", fd_pc, 0);
      chk("rst_npc", fd_npc, 0);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("rst_fault", fetch_fault, 0);
`endif

      // Streaming with ready high
      rdy = 1'b1;
      gnt = 1'b1;
      sb_q.push_back(32'h1000);
      sb_q.push_back(32'h1004);
      sb_q.push_back(32'h1008);
      tick(1'b0, '0, 1'b1);
      chk("first_req", last_req, 1);
      chk("first_addr", last_addr, 32'h1000);
      for (int i = 0; i < 20 && ngrant < 3; i++) tick();
      gnt = 1'b0;
      repeat (6) tick();
      chk("latency", first_vld - first_gnt, 2);
      chk("sb_empty_stream", sb_q.size(), 0);

      // Back-pressure fills FIFO, then drains in order
      rdy = 1'b0;
      gnt = 1'b1;
      g0 = ngrant;
      sb_q.push_back(32'h100C);
      sb_q.push_back(32'h1010);
      sb_q.push_back(32'h1014);
      sb_q.push_back(32'h1018);
      repeat (20) tick();
      chk("full_grants", ngrant - g0, 4);
      chk("full_req_low", last_req, 0);
      chk("stall_valid", fd_valid, 1);
      chk("stall_pc", fd_pc, 32'h100C);
      gnt = 1'b0;
      rdy = 1'b1;
      repeat (8) tick();
      chk("sb_empty_full", sb_q.size(), 0);

      // Reset while waiting on a response; stale rvalid after release
      gnt = 1'b1;
      wait_grant("g_101c", 32'h101C);
      gnt = 1'b0;
      tick();
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_req", imem_req, 0);
      chk("mid_rst_addr", imem_addr, 0);
      chk("mid_rst_valid", fd_valid, 0);
      chk("mid_rst_pc", fd_pc, 0);
      chk("mid_rst_npc", fd_npc, 0);
      p1_v = 1'b1;
      p1_d = 32'h101C ^ XMASK;
      gnt = 1'b1;
      sb_q.push_back(32'h1000);
      tick(1'b0, '0, 1'b1);
      chk("rel_req", last_req, 1);
      chk("rel_addr", last_addr, 32'h1000);
      gnt = 1'b0;
      repeat (5) tick();
      chk("sb_empty_rst", sb_q.size(), 0);

      // Redirect right after grant to 0x1008
      gnt = 1'b1;
      sb_q.push_back(32'h1004);
      wait_grant("g_1008", 32'h1008);
      tick(1'b1, 32'h2000);
      chk("redir_req_low", last_req, 0);
      sb_q.push_back(32'h2000);
      wait_grant("g_2000", 32'h2000);
      gnt = 1'b0;
      repeat (5) tick();
      chk("sb_empty_redir", sb_q.size(), 0);

      // Redirect coincident with rvalid and a decode handshake
      rdy = 1'b0;
      gnt = 1'b1;
      wait_grant("g_2004", 32'h2004);
      tick();
      tick();
      chk("g_2008", {31'd0, last_gnt}, 1);
      chk("g_2008_addr", last_addr, 32'h2008);
      rdy = 1'b1;
      tick(1'b1, 32'h3000);
      chk("coinc_valid", fd_valid, 1);
      sb_q.push_back(32'h3000);
      tick();
      chk("flush_valid", fd_valid, 0);
      chk("flush_req", last_req, 1);
      chk("flush_addr", last_addr, 32'h3000);
      gnt = 1'b0;
      repeat (5) tick();
      chk("sb_empty_coinc", sb_q.size(), 0);

      // Two-cycle memory: redirect in S_WAIT squashes via S_DRAIN
      slow = 1'b1;
      gnt = 1'b1;
      wait_grant("g_3004", 32'h3004);
      tick(1'b1, 32'h4000);
      chk("drain_req0", last_req, 0);
      tick();
      chk("drain_req1", last_req, 0);
      sb_q.push_back(32'h4000);
      wait_grant("g_4000", 32'h4000);
      gnt = 1'b0;
      repeat (6) tick();
      chk("sb_empty_drain", sb_q.size(), 0);
      slow = 1'b0;
      repeat (3) tick();

      // Misaligned redirect
`ifdef FETCH_ALIGN_CHECK_EN
      tick(1'b1, 32'h1002);
      gnt = 1'b1;
      tick();
      chk("fault_set", fetch_fault, 1);
      chk("fault_req", last_req, 0);
      repeat (3) tick();
      chk("fault_sticky", fetch_fault, 1);
      chk("fault_req2", last_req, 0);
      sb_q.push_back(32'h1010);
      tick(1'b1, 32'h1010);
      tick();
      chk("fault_clr", fetch_fault, 0);
      chk("resume_gnt", {31'd0, last_gnt}, 1);
      chk("resume_addr", last_addr, 32'h1010);
`else
      tick(1'b1, 32'h1002);
      sb_q.push_back(32'h1000);
      gnt = 1'b1;
      tick();
      chk("align_gnt", {31'd0, last_gnt}, 1);
      chk("align_addr", last_addr, 32'h1000);
`endif
      gnt = 1'b0;
      repeat (5) tick();
      chk("sb_empty_align", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
